// File: rtl/wb_port_arbiter_pkg.sv
// Shared core constants and the buffered writeback entry type for the
// register-file write port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned PEND_DEPTH = 2;
    localparam int unsigned PEND_CNT_W = 2;
    localparam int unsigned PEND_PTR_W = 1;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wbEntry_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Two-entry FIFO buffering multiply/divide results waiting for the RF write port.
// Push and pop may occur in the same cycle; order is first accepted, first out.
module wb_pend_fifo
    import wb_port_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] pushRd,
    input  logic [XLEN-1:0]       pushData,
    input  logic                  pop,
    output logic [REG_ADDR_W-1:0] headRd,
    output logic [XLEN-1:0]       headData,
    output logic [PEND_CNT_W-1:0] count
);

    wbEntry_t              slots [PEND_DEPTH];
    logic [PEND_PTR_W-1:0] rdPtr;
    logic [PEND_PTR_W-1:0] wrPtr;
    logic                  doPush;
    logic                  doPop;

    assign doPush   = push && (count != PEND_CNT_W'(PEND_DEPTH));
    assign doPop    = pop && (count != '0);
    assign headRd   = slots[rdPtr].rd;
    assign headData = slots[rdPtr].data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < int'(PEND_DEPTH); i++) begin
                slots[i] <= '0;
            end
        end else begin
            if (doPush) begin
                slots[wrPtr] <= '{rd: pushRd, data: pushData};
                wrPtr        <= wrPtr + PEND_PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PEND_PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + PEND_CNT_W'(1);
                2'b01:   count <= count - PEND_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the main pipeline and
// buffered multiply/divide results, forcing a one-cycle stall if MD results starve.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_data,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_rd,
    input  logic [XLEN-1:0]       md_data,
    output logic                  md_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  stall_req,
    output logic [PEND_CNT_W-1:0] pend_count
);

    localparam int unsigned STARVE_W = 4;
    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic                  pipeReq;
    logic                  mdAccept;
    logic                  mdLive;
    logic                  fifoEmpty;
    logic                  grantHead;
    logic                  grantPipe;
    logic                  grantBypass;
    logic                  grantAny;
    logic                  fifoPush;
    logic [REG_ADDR_W-1:0] grantRd;
    logic [XLEN-1:0]       grantData;
    logic [REG_ADDR_W-1:0] headRd;
    logic [XLEN-1:0]       headData;
    logic [PEND_CNT_W-1:0] fifoCount;
    logic [STARVE_W-1:0]   starveCnt;
    logic [STARVE_W-1:0]   starveNext;

    assign md_ready   = (fifoCount < PEND_CNT_W'(PEND_DEPTH)) && !rst;
    assign pend_count = fifoCount;

    // Priority: forced head, pipeline, buffered head, MD bypass; x0 targets never write.
    always_comb begin
        pipeReq     = pipe_we && (pipe_rd != '0) && !stall_req;
        mdAccept    = md_valid && md_ready;
        mdLive      = mdAccept && (md_rd != '0);
        fifoEmpty   = (fifoCount == '0);
        grantHead   = 1'b0;
        grantPipe   = 1'b0;
        grantBypass = 1'b0;
        grantRd     = md_rd;
        grantData   = md_data;
        if (stall_req) begin
            grantHead = 1'b1;
        end else if (pipeReq) begin
            grantPipe = 1'b1;
        end else if (!fifoEmpty) begin
            grantHead = 1'b1;
        end else if (mdLive) begin
            grantBypass = 1'b1;
        end
        if (grantHead) begin
            grantRd   = headRd;
            grantData = headData;
        end else if (grantPipe) begin
            grantRd   = pipe_rd;
            grantData = pipe_data;
        end
        grantAny = grantHead || grantPipe || grantBypass;
        fifoPush = mdLive && !grantBypass;
    end

    // Counts cycles the buffered head waits behind the pipeline.
    always_comb begin
        starveNext = starveCnt;
        if (fifoEmpty || grantHead) begin
            starveNext = '0;
        end else if (starveCnt < LIMIT) begin
            starveNext = starveCnt + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we     <= 1'b0;
            rf_rd     <= '0;
            rf_wdata  <= '0;
            starveCnt <= '0;
            stall_req <= 1'b0;
        end else begin
            rf_we     <= grantAny;
            starveCnt <= starveNext;
            stall_req <= (starveNext == LIMIT);
            if (grantAny) begin
                rf_rd    <= grantRd;
                rf_wdata <= grantData;
            end
        end
    end

    wb_pend_fifo u_pendFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifoPush),
        .pushRd   (md_rd),
        .pushData (md_data),
        .pop      (grantHead),
        .headRd   (headRd),
        .headData (headData),
        .count    (fifoCount)
    );

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive blocked cycles of a buffered MD result before a pipeline stall is forced (legal range 1..15).
REQ-002 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports pipe_we  in  1, pipe_rd  in  5, pipe_data  in  32: the main pipeline writeback request.
REQ-005 SHALL have ports md_valid  in  1, md_rd  in  5, md_data  in  32: the multiply/divide unit result request.
REQ-006 SHALL have port md_ready  out  1: the MD result is accepted in any cycle where md_valid and md_ready are both 1.
REQ-007 SHALL have ports rf_we  out  1, rf_rd  out  5, rf_wdata  out  32: the registered register-file write port.
REQ-008 SHALL have port stall_req  out  1: the pipeline is held this cycle and re-presents its pipe_* request next cycle.
REQ-009 SHALL have port pend_count  out  2: the number of MD results buffered (0..2).

Function
REQ-010 SHALL hold an internal 2-entry FIFO of {rd, data} for MD results; md_ready = (pend_count < 2) and not rst.
REQ-011 SHALL treat pipe_we=1 with pipe_rd=0 as no pipeline request.
REQ-012 SHALL accept an MD result with md_rd=0 and discard it, with no FIFO entry and no rf write.
REQ-013 SHALL arbitrate in priority order each cycle: (a) stall_req=1 -> grant FIFO head; (b) else pipeline request -> grant pipeline; (c) else FIFO non-empty -> grant head; (d) else FIFO empty and MD accepted -> grant MD inputs directly (bypass, no FIFO entry); (e) else no grant.
REQ-014 SHALL ignore pipe_* in any cycle with stall_req=1.
REQ-015 SHALL register the granted {rd, data} onto rf_rd/rf_wdata with rf_we=1 on the next rising edge (1-cycle latency); with no grant, rf_we=0 and rf_rd/rf_wdata hold their previous values.
REQ-016 SHALL permit a push and a pop in the same cycle; pend_count is then unchanged and FIFO order is preserved (FIFO order means first accepted, first written).
REQ-017 SHALL use a 4-bit starvation counter: cleared when the FIFO is empty or the head is granted; otherwise incremented, saturating at STARVE_LIMIT.
REQ-018 SHALL register stall_req=1 for exactly one cycle, the cycle after the counter reaches STARVE_LIMIT; the counter clears in that stall cycle because the head is granted.
REQ-019 SHALL never assert stall_req while the FIFO is empty.
REQ-020 SHALL guarantee that at most one rf write occurs per cycle and that no accepted non-x0 request is dropped.

Reset
REQ-021 SHALL, while rst=1 at a clock edge, clear the FIFO, pend_count=0, starvation counter=0, stall_req=0, rf_we=0, rf_rd=0 and rf_wdata=0.
REQ-022 SHALL drop any buffered MD results when rst is asserted mid-operation; md_ready=0 throughout reset; md_ready=1 in the first cycle after rst deasserts.

Structure
REQ-023 SHALL take the widths REG_ADDR_W=5 and XLEN=32 and the FIFO depth constant 2 from the shared core package.
REQ-024 SHALL implement the buffer as one sub-module, wb_pend_fifo (2-entry, count output, simultaneous push/pop); the arbitration and starvation logic SHALL stay in wb_port_arbiter.

Verification
REQ-025 SHALL cover: pipe_we=1 rd=5 data=0xAAAA0001, md idle -> next cycle rf_we=1 rf_rd=5 rf_wdata=0xAAAA0001.
REQ-026 SHALL cover: FIFO empty, no pipe request, md_valid=1 rd=7 data=0x12345678 -> md_ready=1, next cycle rf_rd=7 rf_wdata=0x12345678, pend_count stays 0.
REQ-027 SHALL cover: pipe_we=1 rd=3 every cycle, two MD pushes (rd=8, rd=9) -> pend_count=2, md_ready=0; stall_req=1 one cycle after the 4th blocked cycle; rd=8 written next; the counter restarts, then rd=9 is forced the same way.
REQ-028 SHALL cover: same-cycle pipe_we=1 rd=0 and md_valid=1 rd=0 -> no rf write, pend_count=0.
REQ-029 SHALL cover: pend_count=1, pop and push in the same cycle -> pend_count stays 1, writes occur in acceptance order.
REQ-030 SHALL cover: pend_count=2, rst=1 for one cycle -> pend_count=0, rf_we=0, stall_req=0, md_ready=1 the cycle after.
